// File: rtl/aes_key_store.sv
// aes_key_store: round-key buffer behind the AES key expander.
// Captures NR+1 round keys, flags a complete schedule, and replays it
// forward (encrypt) or reverse (decrypt) under a valid/ready handshake.
module aes_key_store #(
  parameter int KEY_S = 128,
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_S-1:0] wr_key,
  input  logic             wr_last,
  input  logic             rd_start,
  input  logic             rd_decrypt,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [KEY_S-1:0] rk_data,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_last,
  output logic             keys_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state;
  logic [KEY_S-1:0] mem [0:NR];
  logic [NR:0]      wmask;
  logic [NR:0]      wmask_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] end_idx;
  logic             dir_rev;
  logic             dropped;
  logic             wr_ok;
  logic             start_ok;
  logic             hs_last;
  logic             load;

  // Write qualification, next write mask and stream handshake decode
  always_comb begin
    wr_ok     = (state == IDLE) && wr_en && (wr_idx <= IDX_W'(NR));
    wmask_nxt = wmask;
    if (wr_ok) begin
      if (wr_idx == '0) wmask_nxt = '0;
      wmask_nxt[wr_idx] = 1'b1;
    end
    start_ok = (state == IDLE) && rd_start && keys_valid;
    hs_last  = rk_valid && rk_ready && rk_last;
    load     = !rk_valid || rk_ready;
  end

  // Key storage: not reset, only written while idle
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_key;
  end

  // Control FSM with registered playback outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wmask      <= '0;
      keys_valid <= 1'b0;
      overrun    <= 1'b0;
      dropped    <= 1'b0;
      dir_rev    <= 1'b0;
      ptr        <= '0;
      end_idx    <= '0;
      rk_valid   <= 1'b0;
      rk_data    <= '0;
      rk_idx     <= '0;
      rk_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wmask <= wmask_nxt;
          if (wr_ok && wr_idx == '0) begin
            keys_valid <= 1'b0;
            overrun    <= 1'b0;
          end
          if (wr_en && wr_last) keys_valid <= &wmask_nxt;
          // First key is loaded on the accepting edge so rk_valid rises with busy
          if (start_ok) begin
            state    <= STREAM;
            dir_rev  <= rd_decrypt;
            rk_valid <= 1'b1;
            rk_last  <= 1'b0;
            if (rd_decrypt) begin
              rk_data <= mem[NR];
              rk_idx  <= IDX_W'(NR);
              ptr     <= IDX_W'(NR - 1);
              end_idx <= '0;
            end else begin
              rk_data <= mem[0];
              rk_idx  <= '0;
              ptr     <= IDX_W'(1);
              end_idx <= IDX_W'(NR);
            end
          end
        end
        STREAM: begin
          if (wr_en) begin
            overrun <= 1'b1;
            dropped <= 1'b1;
          end
          // Schedule invalidation from a dropped write is deferred to stream end
          if (hs_last) begin
            state    <= IDLE;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            dropped  <= 1'b0;
            if (dropped || wr_en) keys_valid <= 1'b0;
          end else if (load) begin
            rk_valid <= 1'b1;
            rk_data  <= mem[ptr];
            rk_idx   <= ptr;
            rk_last  <= (ptr == end_idx);
            ptr      <= dir_rev ? ptr - 1'b1 : ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == STREAM);

endmodule
